// File: rtl/sample_replay.sv
`default_nettype none
// ============================================================================
//  Module   : sample_replay
//  Brief    : Bit-serial playback of a host-loaded 1-bit IF sample capture,
//             one sample per clock, single-shot or looped, from a 16-bit RAM.
//  Revision : 1.0  initial release
// ============================================================================
module sample_replay #(
    parameter int DEPTH_WORDS = 4096,
    parameter int AW          = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr,
    input  logic [15:0]   din,
    input  logic          clr,
    input  logic          start,
    input  logic          stop,
    input  logic          loop,
    output logic          dout,
    output logic          active,
    output logic          done,
    output logic          full,
    output logic [AW:0]   count
);

    localparam logic [AW:0]   c_depth   = (AW+1)'(DEPTH_WORDS);
    localparam logic [AW:0]   c_cnt_one = (AW+1)'(1);
    localparam logic [AW-1:0] c_idx_one = AW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_PLAY  = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    state_t         r_state;
    logic [15:0]    r_mem [DEPTH_WORDS];
    logic [15:0]    r_rd_data;
    logic [15:0]    r_shift;
    logic [AW-1:0]  r_widx;
    logic [3:0]     r_bit;
    logic           r_loop;
    logic [AW:0]    r_count;

    logic           w_last_word;
    logic [AW-1:0]  w_next_idx;
    logic [AW-1:0]  w_rd_addr;
    logic           w_wr_en;

    assign full  = (r_count == c_depth);
    assign count = r_count;

    // Loading is only legal while idle so the word count is frozen during a run.
    assign w_wr_en     = wr && !clr && !full && (r_state == S_IDLE);
    assign w_last_word = ({1'b0, r_widx} == (r_count - c_cnt_one));
    assign w_next_idx  = w_last_word ? '0 : (r_widx + c_idx_one);
    // Idle reads word 0 so it is ready by the time PRIME loads the shifter.
    assign w_rd_addr   = (r_state == S_IDLE) ? '0 : w_next_idx;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_count[AW-1:0]] <= din;
        end
        r_rd_data <= r_mem[w_rd_addr];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_shift <= '0;
            r_widx  <= '0;
            r_bit   <= '0;
            r_loop  <= 1'b0;
            dout    <= 1'b0;
            active  <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;

            if (clr && (r_state == S_IDLE)) begin
                r_count <= '0;
            end else if (w_wr_en) begin
                r_count <= r_count + c_cnt_one;
            end

            case (r_state)
                S_IDLE: begin
                    dout   <= 1'b0;
                    active <= 1'b0;
                    if (start && !stop && (r_count != '0)) begin
                        r_loop  <= loop;
                        r_state <= S_PRIME;
                    end
                end
                S_PRIME: begin
                    if (stop) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_shift <= r_rd_data;
                        r_widx  <= '0;
                        r_bit   <= '0;
                        r_state <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (stop) begin
                        dout    <= 1'b0;
                        active  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        dout   <= r_shift[0];
                        active <= 1'b1;
                        r_bit  <= r_bit + 4'd1;
                        // Prefetched word drops in right behind bit 15: no gap.
                        if (r_bit == 4'd15) begin
                            if (w_last_word && !r_loop) begin
                                r_state <= S_FLUSH;
                            end else begin
                                r_shift <= r_rd_data;
                                r_widx  <= w_next_idx;
                            end
                        end else begin
                            r_shift <= {1'b0, r_shift[15:1]};
                        end
                    end
                end
                S_FLUSH: begin
                    dout    <= 1'b0;
                    active  <= 1'b0;
                    done    <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
